// File: rtl/sdram_arbiter_n.sv
// N-client arbiter in front of the 128-bit SDRAM bridge: strict priority for real-time clients, round-robin for the rest.
// Latency: grant and strobe one cycle after a request is seen in IDLE; ack_o one cycle after bridge_acknowledge.
// Backpressure: one bridge transaction at a time; requests stay pending (wait_o) until their ack_o, and a bridge timeout aborts with err_o.
module sdram_arbiter_n #(
  parameter int NUM_CLIENTS = 8,
  parameter int ADDR_W = 22,
  parameter int DATA_W = 128,
  parameter logic [NUM_CLIENTS-1:0] RT_MASK = NUM_CLIENTS'(8'b0000_0011),
  parameter int TIMEOUT = 1023,
  localparam int BE_W = DATA_W / 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_CLIENTS-1:0]      req_i,
  input  logic [NUM_CLIENTS-1:0]      wr_i,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] addr_i,
  input  logic [NUM_CLIENTS*DATA_W-1:0] wrdata_i,
  input  logic [NUM_CLIENTS*BE_W-1:0] be_i,
  output logic [NUM_CLIENTS-1:0]      ack_o,
  output logic [NUM_CLIENTS-1:0]      wait_o,
  output logic [DATA_W-1:0]           rddata_o,
  output logic                        err_o,
  output logic [NUM_CLIENTS-1:0]      grant_o,
  output logic [ADDR_W+3:0]           bridge_address,
  output logic [BE_W-1:0]             bridge_byte_enable,
  output logic                        bridge_read,
  output logic                        bridge_write,
  output logic [DATA_W-1:0]           bridge_write_data,
  input  logic                        bridge_acknowledge,
  input  logic [DATA_W-1:0]           bridge_read_data
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t                 r_state;
  logic [NUM_CLIENTS-1:0] r_grant;
  logic [IDX_W-1:0]       r_owner;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdat;
  logic [BE_W-1:0]        r_be;
  logic                   r_read;
  logic                   r_write;
  logic                   r_wr;
  logic [CNT_W-1:0]       r_cnt;
  logic [NUM_CLIENTS-1:0] r_ack;
  logic                   r_err;
  logic [DATA_W-1:0]      r_rddata;

  logic [NUM_CLIENTS-1:0] w_rt_req;
  logic [NUM_CLIENTS-1:0] w_nrt_req;
  logic                   w_win_vld;
  logic [IDX_W-1:0]       w_win_idx;
  logic [ADDR_W-1:0]      w_win_addr;
  logic [DATA_W-1:0]      w_win_wdat;
  logic [BE_W-1:0]        w_win_be;
  logic                   w_win_wr;

  assign w_rt_req  = req_i & RT_MASK;
  assign w_nrt_req = req_i & ~RT_MASK;

  // Winner: lowest real-time requester, else first non-real-time requester after rr_ptr (descending scans so the last hit is the best).
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (w_rt_req[i]) begin
        w_win_vld = 1'b1;
        w_win_idx = IDX_W'(i);
      end
    end
    if (!w_win_vld) begin
      for (int i = NUM_CLIENTS; i >= 1; i--) begin
        for (int k = 0; k < NUM_CLIENTS; k++) begin
          if (w_nrt_req[k] && (((int'(r_rr_ptr) + i) % NUM_CLIENTS) == k)) begin
            w_win_vld = 1'b1;
            w_win_idx = IDX_W'(k);
          end
        end
      end
    end
  end

  // Mux the winner's address, data, byte enables and direction out of the packed client buses.
  always_comb begin
    w_win_addr = '0;
    w_win_wdat = '0;
    w_win_be   = '0;
    w_win_wr   = 1'b0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (IDX_W'(k) == w_win_idx) begin
        w_win_addr = addr_i[k*ADDR_W +: ADDR_W];
        w_win_wdat = wrdata_i[k*DATA_W +: DATA_W];
        w_win_be   = be_i[k*BE_W +: BE_W];
        w_win_wr   = wr_i[k];
      end
    end
  end

  // Arbitration FSM; grant stays visible through DONE so ack_o and grant_o line up for the owner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_rr_ptr <= IDX_W'(NUM_CLIENTS - 1);
      r_addr   <= '0;
      r_wdat   <= '0;
      r_be     <= '0;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_wr     <= 1'b0;
      r_cnt    <= '0;
      r_ack    <= '0;
      r_err    <= 1'b0;
      r_rddata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack <= '0;
          r_err <= 1'b0;
          if (w_win_vld) begin
            r_grant <= NUM_CLIENTS'(1) << w_win_idx;
            r_owner <= w_win_idx;
            r_addr  <= w_win_addr;
            r_wdat  <= w_win_wdat;
            r_be    <= w_win_wr ? w_win_be : {BE_W{1'b1}};
            r_wr    <= w_win_wr;
            r_read  <= ~w_win_wr;
            r_write <= w_win_wr;
            r_cnt   <= '0;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          // An acknowledge in the abort cycle still counts as a normal completion.
          if (bridge_acknowledge) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_ack   <= r_grant;
            r_err   <= 1'b0;
            if (!r_wr) r_rddata <= bridge_read_data;
            r_state <= DONE;
          end else if ((TIMEOUT != 0) && (r_cnt == TO_VAL)) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_ack   <= r_grant;
            r_err   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          r_ack   <= '0;
          r_err   <= 1'b0;
          r_grant <= '0;
          if (!RT_MASK[r_owner]) r_rr_ptr <= r_owner;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack_o              = r_ack;
  assign wait_o             = req_i & ~r_ack;
  assign rddata_o           = r_rddata;
  assign err_o              = r_err;
  assign grant_o            = r_grant;
  assign bridge_address     = {r_addr, 4'b0000};
  assign bridge_byte_enable = r_be;
  assign bridge_read        = r_read;
  assign bridge_write       = r_write;
  assign bridge_write_data  = r_wdat;

endmodule

// File: tb/tb_sdram_arbiter_n.sv
// Directed bench for sdram_arbiter_n: table of transactions plus reset and stray-acknowledge sequences.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// The bridge model acknowledges after a per-vector number of strobe cycles (0 = never).
module tb_sdram_arbiter_n;

  localparam int N  = 8;
  localparam int AW = 22;
  localparam int DW = 128;
  localparam int BW = DW / 8;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    req_i;
  logic [N-1:0]    wr_i;
  logic [N*AW-1:0] addr_i;
  logic [N*DW-1:0] wrdata_i;
  logic [N*BW-1:0] be_i;
  logic [N-1:0]    ack_o;
  logic [N-1:0]    wait_o;
  logic [DW-1:0]   rddata_o;
  logic            err_o;
  logic [N-1:0]    grant_o;
  logic [AW+3:0]   bridge_address;
  logic [BW-1:0]   bridge_byte_enable;
  logic            bridge_read;
  logic            bridge_write;
  logic [DW-1:0]   bridge_write_data;
  logic            bridge_acknowledge;
  logic [DW-1:0]   bridge_read_data;

  sdram_arbiter_n #(
    .NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .RT_MASK(8'b0000_0011), .TIMEOUT(15)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_i(req_i), .wr_i(wr_i), .addr_i(addr_i),
    .wrdata_i(wrdata_i), .be_i(be_i), .ack_o(ack_o), .wait_o(wait_o),
    .rddata_o(rddata_o), .err_o(err_o), .grant_o(grant_o),
    .bridge_address(bridge_address), .bridge_byte_enable(bridge_byte_enable),
    .bridge_read(bridge_read), .bridge_write(bridge_write),
    .bridge_write_data(bridge_write_data), .bridge_acknowledge(bridge_acknowledge),
    .bridge_read_data(bridge_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] wr;
    int           lat;
    int           own;
    logic         err;
    logic         drop;
  } vec_t;

  vec_t          vecs [18];
  int            n_cmp;
  int            n_err;
  logic [DW-1:0] exp_rd;

  function automatic logic [AW-1:0] addr_of(input int k);
    logic [AW-1:0] a;
    a = 22'h00123 + AW'(((k + 5) % 8) * 22'h10000);
    return a;
  endfunction

  function automatic logic [DW-1:0] wdat_of(input int k);
    logic [7:0] b;
    b = 8'hA0 + 8'(k);
    return {16{b}};
  endfunction

  function automatic logic [BW-1:0] be_of(input int k);
    logic [BW-1:0] b;
    b = (k == 6) ? 16'h00F0 : (16'h8000 | (16'h0001 << k));
    return b;
  endfunction

  function automatic logic [DW-1:0] rd_of(input int i);
    logic [DW-1:0] d;
    d = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    return d ^ DW'(i);
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Entered and left on a falling edge with the DUT in IDLE.
  task automatic run_txn(input int vi, input vec_t v);
    int       sc;
    int       exp_sc;
    logic     owr;
    logic [N-1:0] oh;
    owr = v.wr[v.own];
    oh  = N'(1) << v.own;
    req_i = v.req;
    wr_i  = v.wr;
    @(posedge clk); @(negedge clk);
    check("grant", DW'(grant_o), DW'(oh));
    check("address", DW'(bridge_address), DW'({addr_of(v.own), 4'b0000}));
    check("byte_enable", DW'(bridge_byte_enable), owr ? DW'(be_of(v.own)) : DW'(16'hFFFF));
    check("wait_issue", DW'(wait_o), DW'(req_i));
    if (owr) check("write_data", bridge_write_data, wdat_of(v.own));
    if (v.drop) req_i = '0;
    sc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (!(bridge_read || bridge_write)) break;
      sc++;
      check("strobe_rd", DW'(bridge_read), DW'(!owr));
      check("strobe_wr", DW'(bridge_write), DW'(owr));
      check("ack_early", DW'(ack_o), '0);
      bridge_read_data   = rd_of(vi);
      bridge_acknowledge = (c == v.lat);
      @(posedge clk); @(negedge clk);
      bridge_acknowledge = 1'b0;
    end
    exp_sc = (v.lat == 0) ? 16 : v.lat;
    check("strobe_cycles", DW'(sc), DW'(exp_sc));
    if (!owr && !v.err) exp_rd = rd_of(vi);
    check("ack_pulse", DW'(ack_o), DW'(oh));
    check("err", DW'(err_o), DW'(v.err));
    check("rddata", rddata_o, exp_rd);
    check("wait_done", DW'(wait_o), DW'(req_i & ~oh));
    @(posedge clk); @(negedge clk);
    check("ack_clear", DW'(ack_o), '0);
    check("grant_clear", DW'(grant_o), '0);
    check("err_clear", DW'(err_o), '0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_rd = '0;
    reset_n = 1'b0;
    req_i = '0;
    wr_i = '0;
    bridge_acknowledge = 1'b0;
    bridge_read_data = '0;
    for (int k = 0; k < N; k++) begin
      addr_i[k*AW +: AW]   = addr_of(k);
      wrdata_i[k*DW +: DW] = wdat_of(k);
      be_i[k*BW +: BW]     = be_of(k);
    end

    //             req     wr      lat own err   drop
    vecs[0]  = '{8'h94, 8'h00,  1, 2, 1'b0, 1'b0};
    vecs[1]  = '{8'h94, 8'h00,  1, 4, 1'b0, 1'b0};
    vecs[2]  = '{8'h94, 8'h00,  1, 7, 1'b0, 1'b0};
    vecs[3]  = '{8'h94, 8'h00,  1, 2, 1'b0, 1'b0};
    vecs[4]  = '{8'h94, 8'h00,  1, 4, 1'b0, 1'b0};
    vecs[5]  = '{8'h94, 8'h00,  1, 7, 1'b0, 1'b0};
    vecs[6]  = '{8'h08, 8'h00,  4, 3, 1'b0, 1'b0};
    vecs[7]  = '{8'h23, 8'h00,  1, 0, 1'b0, 1'b0};
    vecs[8]  = '{8'h22, 8'h00,  2, 1, 1'b0, 1'b0};
    vecs[9]  = '{8'h20, 8'h00,  1, 5, 1'b0, 1'b1};
    vecs[10] = '{8'h40, 8'h40,  3, 6, 1'b0, 1'b0};
    vecs[11] = '{8'h08, 8'h00,  0, 3, 1'b1, 1'b0};
    vecs[12] = '{8'h10, 8'h00,  2, 4, 1'b0, 1'b0};
    vecs[13] = '{8'h04, 8'h00, 16, 2, 1'b0, 1'b0};
    vecs[14] = '{8'h0C, 8'h00,  1, 3, 1'b0, 1'b0};
    vecs[15] = '{8'hFF, 8'hA0,  1, 0, 1'b0, 1'b0};
    vecs[16] = '{8'h84, 8'h80,  2, 7, 1'b0, 1'b0};
    vecs[17] = '{8'h84, 8'h00,  1, 2, 1'b0, 1'b0};

    // Reset values, visible without any clock edge.
    #1;
    check("rst_read", DW'(bridge_read), '0);
    check("rst_write", DW'(bridge_write), '0);
    check("rst_ack", DW'(ack_o), '0);
    check("rst_grant", DW'(grant_o), '0);
    check("rst_err", DW'(err_o), '0);
    check("rst_rddata", rddata_o, '0);
    check("rst_address", DW'(bridge_address), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // A stray acknowledge in IDLE must not produce an ack or a grant.
    bridge_acknowledge = 1'b1;
    bridge_read_data = rd_of(99);
    @(posedge clk); @(negedge clk);
    bridge_acknowledge = 1'b0;
    check("idle_ack_ignored", DW'(ack_o), '0);
    check("idle_no_grant", DW'(grant_o), '0);
    check("idle_rddata_hold", rddata_o, '0);

    for (int i = 0; i < 18; i++) run_txn(i, vecs[i]);

    // Reset while a read strobe is up: strobe drops immediately, no ack, rotation restarts at client 0.
    req_i = 8'h10;
    wr_i = '0;
    @(posedge clk); @(negedge clk);
    check("pre_rst_strobe", DW'(bridge_read), DW'(1));
    #2 reset_n = 1'b0;
    #1;
    check("async_strobe", DW'(bridge_read), '0);
    check("async_grant", DW'(grant_o), '0);
    check("async_ack", DW'(ack_o), '0);
    req_i = '0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); @(negedge clk);
      check("rst_hold_ack", DW'(ack_o), '0);
    end
    reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("post_rst_ack", DW'(ack_o), '0);
    exp_rd = '0;
    run_txn(40, '{8'h14, 8'h00, 1, 2, 1'b0, 1'b0});
    run_txn(41, '{8'h14, 8'h00, 2, 4, 1'b0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
